// File: rtl/mem_pkg.sv
// Shared constants for the memory arbiter: command codes, FSM state
// encoding, owner encoding and the latched-transaction record.
package mem_pkg;

    localparam logic MEM_CMD_READ  = 1'b0;
    localparam logic MEM_CMD_WRITE = 1'b1;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_ACCESS = 2'd1;
    localparam logic [1:0] ARB_RESP   = 2'd2;

    localparam logic OWNER_IMEM = 1'b0;
    localparam logic OWNER_DMEM = 1'b1;

    typedef struct packed {
        logic        owner;
        logic        cmd;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } mem_xact_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port and memory command signals around mem_arbiter.
// slave = arbiter side, master = core + memory side.
interface mem_arbiter_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    logic        dmem_req;
    logic        dmem_cmd;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_mask;
    logic [31:0] dmem_write_data;
    logic        dmem_ready;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_data;

    logic [31:0] mem_addr;
    logic [3:0]  mem_mask;
    logic        mem_enable;
    logic        mem_cmd;
    logic [31:0] mem_write_data;
    logic [31:0] mem_load_data;
    logic        mem_valid;

    modport slave (
        input  imem_req, imem_addr,
        input  dmem_req, dmem_cmd, dmem_addr, dmem_mask, dmem_write_data,
        input  mem_load_data, mem_valid,
        output imem_ready, imem_resp_valid, imem_resp_data,
        output dmem_ready, dmem_resp_valid, dmem_resp_data,
        output mem_addr, mem_mask, mem_enable, mem_cmd, mem_write_data
    );

    modport master (
        output imem_req, imem_addr,
        output dmem_req, dmem_cmd, dmem_addr, dmem_mask, dmem_write_data,
        output mem_load_data, mem_valid,
        input  imem_ready, imem_resp_valid, imem_resp_data,
        input  dmem_ready, dmem_resp_valid, dmem_resp_data,
        input  mem_addr, mem_mask, mem_enable, mem_cmd, mem_write_data
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch and data requesters.
// Macro MEM_ARBITER_RR_EN selects round-robin ties; otherwise dmem wins ties.
module mem_arb_pick
    import mem_pkg::*;
(
    input  logic i_imem_req,
    input  logic i_dmem_req,
    input  logic i_rr_ptr,
    output logic o_grant_imem,
    output logic o_grant_dmem
);

    logic w_imem_wins;

`ifdef MEM_ARBITER_RR_EN
    // The pointer only matters when both ports ask in the same cycle.
    assign w_imem_wins = i_imem_req && (!i_dmem_req || (i_rr_ptr == OWNER_IMEM));
`else
    logic w_unused_rr_ptr;
    assign w_unused_rr_ptr = i_rr_ptr;
    assign w_imem_wins     = i_imem_req && !i_dmem_req;
`endif

    assign o_grant_imem = w_imem_wins;
    assign o_grant_dmem = i_dmem_req && !w_imem_wins;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and load/store ports, one
// transaction in flight. Tie policy set by MEM_ARBITER_RR_EN (see mem_arb_pick).
module mem_arbiter
    import mem_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    logic [1:0]  r_state;
    mem_xact_t   r_xact;
    logic [31:0] r_resp_data;
    logic        r_rr_ptr;

    logic        w_idle;
    logic        w_access;
    logic        w_resp;
    logic        w_grant_imem;
    logic        w_grant_dmem;
    logic        w_accept;
    mem_xact_t   w_next_xact;

    assign w_idle   = (r_state == ARB_IDLE);
    assign w_access = (r_state == ARB_ACCESS);
    assign w_resp   = (r_state == ARB_RESP);

    mem_arb_pick u_pick (
        .i_imem_req   (bus.imem_req),
        .i_dmem_req   (bus.dmem_req),
        .i_rr_ptr     (r_rr_ptr),
        .o_grant_imem (w_grant_imem),
        .o_grant_dmem (w_grant_dmem)
    );

    // Ready is held low during reset so every output reads 0 while it is asserted.
    assign bus.imem_ready = w_idle && !reset && w_grant_imem;
    assign bus.dmem_ready = w_idle && !reset && w_grant_dmem;
    assign w_accept       = bus.imem_ready || bus.dmem_ready;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_xact.owner = OWNER_DMEM;
        w_next_xact.cmd   = bus.dmem_cmd;
        w_next_xact.addr  = bus.dmem_addr;
        w_next_xact.mask  = bus.dmem_mask;
        w_next_xact.wdata = (bus.dmem_cmd == MEM_CMD_WRITE) ? bus.dmem_write_data : '0;
        if (w_grant_imem) begin
            w_next_xact.owner = OWNER_IMEM;
            w_next_xact.cmd   = MEM_CMD_READ;
            w_next_xact.addr  = bus.imem_addr;
            w_next_xact.mask  = 4'hF;
            w_next_xact.wdata = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: every register here is small, so all of them take the async reset; nothing is left to power-up value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_xact      <= '0;
            r_resp_data <= '0;
            r_rr_ptr    <= OWNER_IMEM;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_accept) begin
                        r_xact   <= w_next_xact;
                        r_rr_ptr <= ~r_rr_ptr;
                        r_state  <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    r_resp_data <= ((r_xact.cmd == MEM_CMD_READ) && bus.mem_valid)
                                   ? bus.mem_load_data : '0;
                    r_state     <= ARB_RESP;
                end
                ARB_RESP: r_state <= ARB_IDLE;
                default:  r_state <= ARB_IDLE;
            endcase
        end
    end

    // mem_enable comes straight from the state register, so reset drops it at once.
    assign bus.mem_enable     = w_access;
    assign bus.mem_addr       = w_access ? r_xact.addr  : '0;
    assign bus.mem_mask       = w_access ? r_xact.mask  : '0;
    assign bus.mem_cmd        = w_access ? r_xact.cmd   : MEM_CMD_READ;
    assign bus.mem_write_data = w_access ? r_xact.wdata : '0;

    assign bus.imem_resp_valid = w_resp && (r_xact.owner == OWNER_IMEM);
    assign bus.dmem_resp_valid = w_resp && (r_xact.owner == OWNER_DMEM);
    assign bus.imem_resp_data  = bus.imem_resp_valid ? r_resp_data : '0;
    assign bus.dmem_resp_data  = bus.dmem_resp_valid ? r_resp_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions plus
// hand-written sequences for reset mid-access, ties and back-to-back accepts.
module tb_mem_arbiter;
    import mem_pkg::*;

    typedef struct {
        logic        imem_req;
        logic [31:0] imem_addr;
        logic        dmem_req;
        logic        dmem_cmd;
        logic [31:0] dmem_addr;
        logic [3:0]  dmem_mask;
        logic [31:0] dmem_wdata;
        logic        mem_ok;
        logic        exp_owner;
        logic [31:0] exp_addr;
        logic [3:0]  exp_mask;
        logic        exp_cmd;
        logic [31:0] exp_wdata;
        logic [31:0] exp_resp;
    } vec_t;

    logic clk;
    logic reset;
    logic tb_init;
    logic mem_ok;
    logic [31:0] mem_array [256];
    int n_checks;
    int n_errors;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: combinational read, byte-masked write on the clock edge.
    assign bus.mem_load_data = mem_array[bus.mem_addr[9:2]];
    assign bus.mem_valid     = bus.mem_enable & mem_ok;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) mem_array[i] <= 32'h0;
            mem_array[4] <= 32'h0000_0013;
        end else if (bus.mem_enable && bus.mem_cmd == MEM_CMD_WRITE) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_mask[b])
                    mem_array[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_write_data[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk_fetch(input logic [31:0] addr, input logic ok, input logic [31:0] resp);
        vec_t v;
        v = '{imem_req: 1'b1, imem_addr: addr, dmem_req: 1'b0, dmem_cmd: MEM_CMD_READ,
              dmem_addr: 32'h0, dmem_mask: 4'h0, dmem_wdata: 32'h0, mem_ok: ok,
              exp_owner: OWNER_IMEM, exp_addr: addr, exp_mask: 4'hF, exp_cmd: MEM_CMD_READ,
              exp_wdata: 32'h0, exp_resp: resp};
        return v;
    endfunction

    function automatic vec_t mk_data(input logic cmd, input logic [31:0] addr, input logic [3:0] mask,
                                     input logic [31:0] wdata, input logic [31:0] resp);
        vec_t v;
        v = '{imem_req: 1'b0, imem_addr: 32'h0, dmem_req: 1'b1, dmem_cmd: cmd,
              dmem_addr: addr, dmem_mask: mask, dmem_wdata: wdata, mem_ok: 1'b1,
              exp_owner: OWNER_DMEM, exp_addr: addr, exp_mask: mask, exp_cmd: cmd,
              exp_wdata: (cmd == MEM_CMD_WRITE) ? wdata : 32'h0, exp_resp: resp};
        return v;
    endfunction

    // Called at a negedge with the arbiter in IDLE; returns at the negedge it is IDLE again.
    task automatic run_vec(input vec_t v, input int idx);
        bus.imem_req        = v.imem_req;
        bus.imem_addr       = v.imem_addr;
        bus.dmem_req        = v.dmem_req;
        bus.dmem_cmd        = v.dmem_cmd;
        bus.dmem_addr       = v.dmem_addr;
        bus.dmem_mask       = v.dmem_mask;
        bus.dmem_write_data = v.dmem_wdata;
        mem_ok              = v.mem_ok;
        #1;
        check($sformatf("v%0d imem_ready", idx), bus.imem_ready, v.exp_owner == OWNER_IMEM);
        check($sformatf("v%0d dmem_ready", idx), bus.dmem_ready, v.exp_owner == OWNER_DMEM);
        @(negedge clk);
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        #1;
        check($sformatf("v%0d mem_enable", idx), bus.mem_enable, 1);
        check($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.exp_addr);
        check($sformatf("v%0d mem_mask", idx), bus.mem_mask, v.exp_mask);
        check($sformatf("v%0d mem_cmd", idx), bus.mem_cmd, v.exp_cmd);
        check($sformatf("v%0d mem_wdata", idx), bus.mem_write_data, v.exp_wdata);
        check($sformatf("v%0d access_no_ready", idx), {bus.imem_ready, bus.dmem_ready}, 0);
        check($sformatf("v%0d access_no_resp", idx), {bus.imem_resp_valid, bus.dmem_resp_valid}, 0);
        @(negedge clk);
        #1;
        check($sformatf("v%0d imem_resp_valid", idx), bus.imem_resp_valid, v.exp_owner == OWNER_IMEM);
        check($sformatf("v%0d dmem_resp_valid", idx), bus.dmem_resp_valid, v.exp_owner == OWNER_DMEM);
        check($sformatf("v%0d resp_data", idx),
              (v.exp_owner == OWNER_IMEM) ? bus.imem_resp_data : bus.dmem_resp_data, v.exp_resp);
        check($sformatf("v%0d resp_idle_mem", idx), {bus.mem_enable, bus.mem_addr}, 0);
        check($sformatf("v%0d resp_no_ready", idx), {bus.imem_ready, bus.dmem_ready}, 0);
        @(negedge clk);
    endtask

    // Both ports request together; called at a negedge with the arbiter in IDLE.
    task automatic tie_seq();
        logic exp_own [4];
        logic [31:0] exp_addr;
        logic [31:0] exp_resp;
`ifdef MEM_ARBITER_RR_EN
        exp_own = '{OWNER_IMEM, OWNER_DMEM, OWNER_IMEM, OWNER_DMEM};
`else
        exp_own = '{OWNER_DMEM, OWNER_DMEM, OWNER_DMEM, OWNER_DMEM};
`endif
        bus.imem_req  = 1'b1;
        bus.imem_addr = 32'h0000_0010;
        bus.dmem_req  = 1'b1;
        bus.dmem_cmd  = MEM_CMD_READ;
        bus.dmem_addr = 32'h0000_0014;
        bus.dmem_mask = 4'hF;
        bus.dmem_write_data = 32'h0;
        mem_ok = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_addr = (exp_own[g] == OWNER_IMEM) ? 32'h0000_0010 : 32'h0000_0014;
            exp_resp = (exp_own[g] == OWNER_IMEM) ? 32'h0000_0013 : 32'h1234_0000;
            #1;
            check($sformatf("tie%0d imem_ready", g), bus.imem_ready, exp_own[g] == OWNER_IMEM);
            check($sformatf("tie%0d dmem_ready", g), bus.dmem_ready, exp_own[g] == OWNER_DMEM);
            @(negedge clk);
            #1;
            check($sformatf("tie%0d access_no_ready", g), {bus.imem_ready, bus.dmem_ready}, 0);
            check($sformatf("tie%0d mem_addr", g), bus.mem_addr, exp_addr);
            @(negedge clk);
            if (g == 3) bus.dmem_req = 1'b0;
            #1;
            check($sformatf("tie%0d resp_no_ready", g), {bus.imem_ready, bus.dmem_ready}, 0);
            check($sformatf("tie%0d resp_owner", g), {bus.imem_resp_valid, bus.dmem_resp_valid},
                  (exp_own[g] == OWNER_IMEM) ? 2'b10 : 2'b01);
            check($sformatf("tie%0d resp_data", g),
                  bus.imem_resp_data | bus.dmem_resp_data, exp_resp);
            @(negedge clk);
        end
        #1;
        check("release imem_ready", bus.imem_ready, 1);
        check("release dmem_ready", bus.dmem_ready, 0);
        @(negedge clk);
        bus.imem_req = 1'b0;
        #1;
        check("release mem_addr", bus.mem_addr, 32'h0000_0010);
        @(negedge clk);
        #1;
        check("release imem_resp", {bus.imem_resp_valid, bus.imem_resp_data}, {1'b1, 32'h0000_0013});
        @(negedge clk);
    endtask

    vec_t vecs [8];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        tb_init = 1'b1;
        mem_ok = 1'b1;
        bus.imem_req = 1'b0;
        bus.imem_addr = 32'h0;
        bus.dmem_req = 1'b0;
        bus.dmem_cmd = MEM_CMD_READ;
        bus.dmem_addr = 32'h0;
        bus.dmem_mask = 4'h0;
        bus.dmem_write_data = 32'h0;

        vecs[0] = mk_fetch(32'h0000_0010, 1'b1, 32'h0000_0013);
        vecs[1] = mk_data(MEM_CMD_WRITE, 32'h0000_0100, 4'b0011, 32'hAABB_CCDD, 32'h0);
        vecs[2] = mk_data(MEM_CMD_READ,  32'h0000_0100, 4'hF,    32'hDEAD_BEEF, 32'h0000_CCDD);
        vecs[3] = mk_fetch(32'h0000_0100, 1'b1, 32'h0000_CCDD);
        vecs[4] = mk_data(MEM_CMD_WRITE, 32'h0000_0014, 4'b1100, 32'h1234_5678, 32'h0);
        vecs[5] = mk_data(MEM_CMD_READ,  32'h0000_0014, 4'b0101, 32'h0,         32'h1234_0000);
        vecs[6] = mk_fetch(32'h0000_0017, 1'b1, 32'h1234_0000);
        vecs[7] = mk_fetch(32'h0000_0010, 1'b0, 32'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.imem_req = 1'b1;
        bus.dmem_req = 1'b1;
        #1;
        check("reset ready", {bus.imem_ready, bus.dmem_ready}, 0);
        check("reset mem_enable", bus.mem_enable, 0);
        check("reset mem_addr", bus.mem_addr, 0);
        check("reset resp_valid", {bus.imem_resp_valid, bus.dmem_resp_valid}, 0);
        @(negedge clk);
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        tb_init = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Store abandoned by reset in its ACCESS cycle.
        bus.dmem_req = 1'b1;
        bus.dmem_cmd = MEM_CMD_WRITE;
        bus.dmem_addr = 32'h0000_0100;
        bus.dmem_mask = 4'hF;
        bus.dmem_write_data = 32'hFFFF_FFFF;
        #1;
        check("rst_mid accept", bus.dmem_ready, 1);
        @(negedge clk);
        bus.dmem_req = 1'b0;
        #1;
        check("rst_mid enable_before", bus.mem_enable, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid enable_drop", bus.mem_enable, 0);
        check("rst_mid addr_drop", bus.mem_addr, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("rst_mid no_resp%0d", c), {bus.imem_resp_valid, bus.dmem_resp_valid}, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        tie_seq();

        run_vec(mk_data(MEM_CMD_READ, 32'h0000_0100, 4'hF, 32'h0, 32'h0000_CCDD), 8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
